// File: rtl/mmips_hazard_pkg.sv
// Shared encodings and instruction layout for the mMips hazard/forwarding unit.
package mmips_hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_BRSTALL = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_e;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] low;
    } instr_t;

    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-stage hazard bus: pipeline status in, stall/forward controls out.
interface hazard_fwd_unit_if #(
    parameter int unsigned REG_AW = 5
);
    logic              enable;
    logic              dmem_wait;
    logic              imem_wait;
    logic [31:0]       instr;
    logic [1:0]        branch_op_id;
    logic              idex_regwrite;
    logic              idex_memread;
    logic [REG_AW-1:0] idex_wreg;
    logic              exmem_regwrite;
    logic [REG_AW-1:0] exmem_wreg;
    logic              memwb_regwrite;
    logic [REG_AW-1:0] memwb_wreg;

    logic              pc_write;
    logic              ifid_write;
    logic              bubble;
    logic              pipe_en;
    logic              imem_en;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [1:0]        stall_state;

    modport master (
        output enable, dmem_wait, imem_wait, instr, branch_op_id,
               idex_regwrite, idex_memread, idex_wreg,
               exmem_regwrite, exmem_wreg, memwb_regwrite, memwb_wreg,
        input  pc_write, ifid_write, bubble, pipe_en, imem_en,
               fwd_a, fwd_b, stall_state
    );

    modport slave (
        input  enable, dmem_wait, imem_wait, instr, branch_op_id,
               idex_regwrite, idex_memread, idex_wreg,
               exmem_regwrite, exmem_wreg, memwb_regwrite, memwb_wreg,
        output pc_write, ifid_write, bubble, pipe_en, imem_en,
               fwd_a, fwd_b, stall_state
    );
endinterface

// File: rtl/fwd_sel.sv
// Operand forwarding select for one source register; EX/MEM wins over MEM/WB.
module fwd_sel
    import mmips_hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_wreg,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_wreg,
    output logic [1:0]        sel
);

    // r0 is hardwired zero, so it is never forwarded
    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (exmem_regwrite && (exmem_wreg == src)) begin
                sel = FWD_EXMEM;
            end else if (memwb_regwrite && (memwb_wreg == src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// mMips hazard detection and forwarding control: load-use and branch bubbles
// via a counted stall FSM, plus combinational operand forwarding selects.
module hazard_fwd_unit
    import mmips_hazard_pkg::*;
#(
    parameter int unsigned REG_AW            = 5,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned BRANCH_BUBBLES    = 1,
    parameter int unsigned CNT_W             = 3
) (
    input  logic             clk,
    input  logic             rst,
    hazard_fwd_unit_if.slave bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    instr_t             ins;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic               br;
    logic               lu;
    logic               hold;
    logic               run_br;
    logic               run_ld;
    logic               br_path;
    logic               ld_path;
    logic               last_br;
    logic [1:0]         fwd_a_sel;
    logic [1:0]         fwd_b_sel;
    logic               unused_instr_low;

    assign ins              = bus.instr;
    assign rs               = REG_AW'(ins.rs);
    assign rt               = REG_AW'(ins.rt);
    assign unused_instr_low = ^ins.low;

    assign br   = (bus.branch_op_id != 2'b00);
    assign lu   = bus.idex_regwrite && bus.idex_memread && (bus.idex_wreg != '0) &&
                  ((bus.idex_wreg == rs) || (bus.idex_wreg == rt));
    assign hold = !bus.enable || bus.dmem_wait || bus.imem_wait;

    // Branch detection outranks a simultaneous load-use hit
    assign run_br  = (state_q == ST_RUN) && br;
    assign run_ld  = (state_q == ST_RUN) && !br && lu;
    assign br_path = run_br || (state_q == ST_BRSTALL);
    assign ld_path = run_ld || (state_q == ST_LDSTALL);
    assign last_br = ((state_q == ST_BRSTALL) && (cnt_q == '0)) ||
                     (run_br && (BRANCH_BUBBLES == 1));

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src            (rs),
        .exmem_regwrite (bus.exmem_regwrite),
        .exmem_wreg     (bus.exmem_wreg),
        .memwb_regwrite (bus.memwb_regwrite),
        .memwb_wreg     (bus.memwb_wreg),
        .sel            (fwd_a_sel)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src            (rt),
        .exmem_regwrite (bus.exmem_regwrite),
        .exmem_wreg     (bus.exmem_wreg),
        .memwb_regwrite (bus.memwb_regwrite),
        .memwb_wreg     (bus.memwb_wreg),
        .sel            (fwd_b_sel)
    );

    // Stall sequencing; a running count is never re-armed until back in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            case (state_q)
                ST_RUN: begin
                    if (br) begin
                        state_d = ST_BRSTALL;
                        cnt_d   = CNT_W'(BRANCH_BUBBLES - 1);
                    end else if (lu) begin
                        state_d = ST_LDSTALL;
                        cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
                    end
                end
                ST_LDSTALL, ST_BRSTALL: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pipeline control decode: disable > memory freeze > hazard bubble > normal flow
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
        bus.bubble     = 1'b0;
        bus.pipe_en    = 1'b0;
        bus.imem_en    = 1'b0;
        bus.fwd_a      = 2'b00;
        bus.fwd_b      = 2'b00;
        if (!rst) begin
            bus.fwd_a = fwd_a_sel;
            bus.fwd_b = fwd_b_sel;
            if (bus.enable) begin
                if (bus.dmem_wait || bus.imem_wait) begin
                    bus.imem_en = !bus.dmem_wait;
                end else if (br_path || ld_path) begin
                    bus.pipe_en = 1'b1;
                    bus.bubble  = 1'b1;
                    if (br_path && last_br) begin
                        bus.pc_write = 1'b1;
                        bus.imem_en  = 1'b1;
                    end
                end else begin
                    bus.pipe_en    = 1'b1;
                    bus.ifid_write = 1'b1;
                    bus.pc_write   = !is_cond_branch(ins.opcode);
                    bus.imem_en    = !is_cond_branch(ins.opcode);
                end
            end
        end
    end

    assign bus.stall_state = state_q;

endmodule
